// File: rtl/writeback_unit.sv
// writeback_unit: retirement stage of the single-issue RV32I core.
// Owns the architectural state (32x32 register file, PC, cycle/instret
// counters), commits instructions presented by execute_unit, and halts the
// core when a control-flow target is not 4-byte aligned.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   exec_valid, stall   instruction available / downstream not ready
//   rd_index, result,   writeback destination, value, and write enable
//   need_write_rd
//   pc_next             next PC from execute/branch logic
//   rs1_index/rs1_data  combinational register read port 1
//   rs2_index/rs2_data  combinational register read port 2
//   pc_read_data        current architectural PC
//   commit              instruction retires this cycle (combinational)
//   halted, trap_pc,    halt status, faulting PC, misaligned target
//   trap_target
//   halt_clear          resume at trap_pc+4 when halted
//   cycle_count,        free-running cycle and retired-instruction counters
//   instret_count
module writeback_unit #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exec_valid,
  input  logic                     stall,
  input  logic [4:0]               rd_index,
  input  logic [31:0]              result,
  input  logic                     need_write_rd,
  input  logic [31:0]              pc_next,
  input  logic [4:0]               rs1_index,
  input  logic [4:0]               rs2_index,
  output logic [31:0]              rs1_data,
  output logic [31:0]              rs2_data,
  output logic [31:0]              pc_read_data,
  output logic                     commit,
  output logic                     halted,
  output logic [31:0]              trap_pc,
  output logic [31:0]              trap_target,
  input  logic                     halt_clear,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] instret_count
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [31:0] regs [32];
  logic        misaligned;

  assign misaligned = (pc_next[1:0] != 2'b00);
  assign commit     = (state == ST_RUN) && exec_valid && !stall;
  assign halted     = (state == ST_HALTED);

  // x0 is forced to zero on read; no bypass of a same-cycle write.
  assign rs1_data = (rs1_index == 5'd0) ? '0 : regs[rs1_index];
  assign rs2_data = (rs2_index == 5'd0) ? '0 : regs[rs2_index];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_BOOT;
      pc_read_data  <= RESET_VECTOR;
      cycle_count   <= '0;
      instret_count <= '0;
      trap_pc       <= '0;
      trap_target   <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i[4:0]] <= '0;
      end
    end else begin
      cycle_count <= cycle_count + CNT_ONE;
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (commit) begin
            if (misaligned) begin
              // Faulting instruction does not retire: PC, regs, instret hold.
              trap_pc     <= pc_read_data;
              trap_target <= pc_next;
              state       <= ST_HALTED;
            end else begin
              pc_read_data  <= pc_next;
              instret_count <= instret_count + CNT_ONE;
              if (need_write_rd && (rd_index != 5'd0)) begin
                regs[rd_index] <= result;
              end
            end
          end
        end
        ST_HALTED: begin
          if (halt_clear) begin
            pc_read_data <= trap_pc + 32'd4;
            state        <= ST_RUN;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural architectural model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_valid;
  logic        stall;
  logic [4:0]  rd_index;
  logic [31:0] result;
  logic        need_write_rd;
  logic [31:0] pc_next;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc_read_data;
  logic        commit;
  logic        halted;
  logic [31:0] trap_pc;
  logic [31:0] trap_target;
  logic        halt_clear;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  always #5 clk = ~clk;

  writeback_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .COUNTER_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exec_valid   (exec_valid),
    .stall        (stall),
    .rd_index     (rd_index),
    .result       (result),
    .need_write_rd(need_write_rd),
    .pc_next      (pc_next),
    .rs1_index    (rs1_index),
    .rs2_index    (rs2_index),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .pc_read_data (pc_read_data),
    .commit       (commit),
    .halted       (halted),
    .trap_pc      (trap_pc),
    .trap_target  (trap_target),
    .halt_clear   (halt_clear),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Architectural model: plain variables updated per clock edge.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_trap_pc, m_trap_target;
  logic [63:0] m_cycle, m_instret;
  bit          m_booting, m_halted, m_known;

  task automatic model_edge(input bit rst, input bit ev, input bit st, input logic [4:0] rd,
                            input logic [31:0] res, input bit nw, input logic [31:0] pcn,
                            input bit hc);
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_pc = 32'h0; m_trap_pc = 32'h0; m_trap_target = 32'h0;
      m_cycle = 64'h0; m_instret = 64'h0;
      m_booting = 1'b1; m_halted = 1'b0; m_known = 1'b1;
    end else begin
      m_cycle = m_cycle + 64'd1;
      if (m_booting) m_booting = 1'b0;
      else if (m_halted) begin
        if (hc) begin
          m_pc = m_trap_pc + 32'd4;
          m_halted = 1'b0;
        end
      end else if (ev && !st) begin
        if (pcn % 4 != 0) begin
          m_trap_pc = m_pc; m_trap_target = pcn; m_halted = 1'b1;
        end else begin
          m_pc = pcn;
          m_instret = m_instret + 64'd1;
          if (nw && rd != 0) m_regs[rd] = res;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    return (idx == 0) ? 32'h0 : m_regs[idx];
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, take the
  // edge, advance the model, then check registered state.
  task automatic run_cycle(input bit rst, input bit ev, input bit st, input logic [4:0] rd,
                           input logic [31:0] res, input bit nw, input logic [31:0] pcn,
                           input logic [4:0] r1, input logic [4:0] r2, input bit hc);
    bit exp_commit;
    @(negedge clk);
    rst_n = rst; exec_valid = ev; stall = st; rd_index = rd; result = res;
    need_write_rd = nw; pc_next = pcn; rs1_index = r1; rs2_index = r2; halt_clear = hc;
    #1;
    if (m_known) begin
      exp_commit = !m_booting && !m_halted && ev && !st;
      check_value("commit", {63'h0, commit}, {63'h0, exp_commit});
      check_value("rs1_data", {32'h0, rs1_data}, {32'h0, model_read(r1)});
      check_value("rs2_data", {32'h0, rs2_data}, {32'h0, model_read(r2)});
    end
    @(posedge clk);
    model_edge(rst, ev, st, rd, res, nw, pcn, hc);
    #1;
    check_value("pc", {32'h0, pc_read_data}, {32'h0, m_pc});
    check_value("halted", {63'h0, halted}, {63'h0, m_halted});
    check_value("trap_pc", {32'h0, trap_pc}, {32'h0, m_trap_pc});
    check_value("trap_target", {32'h0, trap_target}, {32'h0, m_trap_target});
    check_value("cycle_count", cycle_count, m_cycle);
    check_value("instret_count", instret_count, m_instret);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    run_cycle(1, 0, 0, 5'd0, 32'h0, 0, m_pc + 32'd4, r1, r2, 0);
  endtask

  initial begin
    logic [31:0] pcn;
    logic [4:0]  rd;
    int          sel;

    m_known = 1'b0;
    rst_n = 1'b0; exec_valid = 1'b0; stall = 1'b0; rd_index = '0; result = '0;
    need_write_rd = 1'b0; pc_next = '0; rs1_index = '0; rs2_index = '0; halt_clear = 1'b0;

    // Reset then idle through BOOT.
    run_cycle(0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd0, 5'd0, 0);
    run_cycle(0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd0, 5'd0, 0);
    run_cycle(1, 1, 0, 5'd3, 32'h55, 1, 32'h4, 5'd3, 5'd0, 0);   // BOOT: must not commit
    check_value("boot_cycle", cycle_count, 64'd1);
    check_value("boot_pc", {32'h0, pc_read_data}, 64'h0);
    check_value("boot_instret", instret_count, 64'd0);

    // Register write then read back.
    run_cycle(1, 1, 0, 5'd5, 32'hDEAD_BEEF, 1, m_pc + 32'd4, 5'd5, 5'd0, 0);
    check_value("rd5_value", {32'h0, rs1_data}, 64'hDEAD_BEEF);
    check_value("rd5_pc", {32'h0, pc_read_data}, 64'h4);
    check_value("rd5_instret", instret_count, 64'd1);

    // x0 write dropped; need_write_rd=0 dropped; both retire.
    run_cycle(1, 1, 0, 5'd0, 32'h1234, 1, m_pc + 32'd4, 5'd0, 5'd6, 0);
    run_cycle(1, 1, 0, 5'd6, 32'hFFFF, 0, m_pc + 32'd4, 5'd0, 5'd6, 0);
    check_value("x0_read", {32'h0, rs1_data}, 64'h0);
    check_value("nowrite_read", {32'h0, rs2_data}, 64'h0);
    check_value("nowrite_instret", instret_count, 64'd3);

    // Stall for three cycles, then release.
    repeat (3) run_cycle(1, 1, 1, 5'd7, 32'h7777, 1, m_pc + 32'd4, 5'd7, 5'd0, 0);
    check_value("stall_pc", {32'h0, pc_read_data}, 64'hC);
    check_value("stall_reg7", {32'h0, rs1_data}, 64'h0);
    run_cycle(1, 1, 0, 5'd7, 32'h7777, 1, m_pc + 32'd4, 5'd7, 5'd0, 0);
    check_value("unstall_reg7", {32'h0, rs1_data}, 64'h7777);

    // Misaligned target from PC 0x100, then resume.
    run_cycle(1, 1, 0, 5'd0, 32'h0, 0, 32'h100, 5'd0, 5'd0, 0);
    run_cycle(1, 1, 0, 5'd8, 32'hAAAA, 1, 32'h102, 5'd8, 5'd0, 0);
    check_value("trap_halted", {63'h0, halted}, 64'h1);
    check_value("trap_pc_val", {32'h0, trap_pc}, 64'h100);
    check_value("trap_tgt_val", {32'h0, trap_target}, 64'h102);
    check_value("trap_pc_hold", {32'h0, pc_read_data}, 64'h100);
    check_value("trap_no_write", {32'h0, rs1_data}, 64'h0);
    run_cycle(1, 1, 0, 5'd8, 32'hBBBB, 1, 32'h200, 5'd8, 5'd0, 0);   // frozen while halted
    run_cycle(1, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd8, 5'd0, 1);
    check_value("resume_pc", {32'h0, pc_read_data}, 64'h104);
    check_value("resume_halted", {63'h0, halted}, 64'h0);
    run_cycle(1, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd0, 5'd0, 1);        // ignored in RUN

    // Reset wins over halt_clear while halted.
    run_cycle(1, 1, 0, 5'd0, 32'h0, 0, 32'h3, 5'd0, 5'd0, 0);
    run_cycle(0, 1, 0, 5'd0, 32'h0, 0, 32'h0, 5'd5, 5'd7, 1);
    check_value("rst_pc", {32'h0, pc_read_data}, 64'h0);
    check_value("rst_halted", {63'h0, halted}, 64'h0);
    check_value("rst_reg5", {32'h0, rs1_data}, 64'h0);
    check_value("rst_cycle", cycle_count, 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)      pcn = m_pc + 32'($urandom_range(1, 3));
      else if (sel == 1) pcn = $urandom & 32'hFFFF_FFFC;
      else               pcn = m_pc + 32'd4;
      rd = 5'($urandom_range(0, 31));
      run_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, rd, $urandom, $urandom_range(0, 3) != 0,
                pcn, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Retirement stage directly downstream of execute_unit in the single-issue RV32I core.
- Consumes rd_index/result/need_write_rd/pc_next from execute_unit.
- Owns the architectural state: 32x32 integer register file, PC register, cycle/instret counters.
- Feeds rs1/rs2 data and the current PC back to decode/execute, and halts the core on a misaligned control-flow target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- COUNTER_WIDTH, 64, width of cycle and instret counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- exec_valid  input  1  execute_unit presents a completed instruction this cycle.
- stall  input  1  downstream memory not ready; blocks commit.
- rd_index  input  5  destination register index.
- result  input  32  value to write to rd.
- need_write_rd  input  1  instruction writes rd.
- pc_next  input  32  next PC computed by execute/branch logic.
- rs1_index  input  5  read port 1 index.
- rs2_index  input  5  read port 2 index.
- rs1_data  output  32  register file read port 1, combinational.
- rs2_data  output  32  register file read port 2, combinational.
- pc_read_data  output  32  current architectural PC.
- commit  output  1  instruction retires this cycle, combinational.
- halted  output  1  core halted on misaligned target.
- trap_pc  output  32  PC of the faulting instruction.
- trap_target  output  32  misaligned pc_next that caused the halt.
- halt_clear  input  1  leave HALTED; resume at trap_pc+4.
- cycle_count  output  COUNTER_WIDTH  cycles since reset.
- instret_count  output  COUNTER_WIDTH  retired instructions since reset.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Go to BOOT.
  - pc_read_data=RESET_VECTOR.
  - All 32 registers, cycle_count, instret_count, trap_pc and trap_target = 0; halted=0.
  - Reset asserted mid-operation wins over every other event in that cycle.
- States: BOOT, RUN, HALTED.
  - BOOT: lasts exactly one cycle after rst_n deasserts; commit=0; then RUN.
  - RUN: commit = exec_valid & ~stall.
  - HALTED: commit=0, PC and registers frozen. halt_clear=1 at an edge loads pc_read_data=trap_pc+4, clears halted, returns to RUN. halt_clear is ignored outside HALTED.
- Commit in RUN (commit=1):
  - If pc_next[1:0]==0:
    - PC <= pc_next.
    - If need_write_rd and rd_index!=0, regs[rd_index] <= result.
    - instret_count += 1.
  - If pc_next[1:0]!=0 (misaligned):
    - No register write, PC holds, instret unchanged.
    - trap_pc <= pc_read_data, trap_target <= pc_next, halted<=1, go to HALTED.
- exec_valid=0 or stall=1: no state change except cycle_count.
- x0: reads always return 0; writes to index 0 are dropped.
- Read ports reflect state before the edge; no write-through bypass (single-cycle core, write lands at the same edge that advances PC).
- cycle_count increments every cycle after reset, in all states; it wraps modulo 2^COUNTER_WIDTH. instret_count also wraps, with no saturation.
- PC arithmetic is 32-bit modulo; trap_pc+4 wraps at 2^32.
- halted output equals (state==HALTED).

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high, exec_valid=0 -> pc_read_data=RESET_VECTOR, commit=0 in the BOOT cycle, cycle_count=1 after the first post-BOOT edge, instret_count=0.
- Register write/read: commit rd=5, result=32'hDEAD_BEEF, need_write_rd=1, pc_next=PC+4 -> next cycle rs1_index=5 gives 32'hDEAD_BEEF, PC advanced by 4, instret_count=1.
- x0 and no-write: commit rd=0 with result=32'h1234, then rd=6 with need_write_rd=0 -> rs1(0)=0 and rs2(6)=0; instret_count increments for both.
- Stall: exec_valid=1, stall=1 for 3 cycles with rd=7 -> commit=0, reg7 unchanged, PC held, cycle_count +3, instret unchanged; drop stall -> write lands on the next edge.
- Misaligned target: PC=32'h100, pc_next=32'h102 -> halted=1, trap_pc=32'h100, trap_target=32'h102, no rd write, PC stays 32'h100. Pulse halt_clear -> PC=32'h104, RUN.
- Reset mid-HALTED with halt_clear=1 at the same edge -> BOOT, PC=RESET_VECTOR, halted=0, registers and counters zero.
